// File: rtl/sys_ctrl_burst.sv
// System controller: decodes UART RX command frames into RF / ALU accesses and returns results over UART TX.
// Latency: RF write strobe 1 cycle after the last byte, read strobe 1 cycle after the addr byte, first TX 1 cycle after read data.
// Backpressure: every TX byte waits for Busy low, then Busy high, then Busy low; RX bytes arriving while not expecting one are dropped.
module sys_ctrl_burst #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    RF_ADDR       = 4,
   parameter int                    ALU_OUT_BYTES = 2,
   parameter logic [DATA_WIDTH-1:0] ERR_CODE      = 8'hEE
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic [DATA_WIDTH-1:0]               UART_RX_DATA,
   input  logic                                UART_RX_VLD,
   input  logic                                UART_TX_Busy,
   output logic [DATA_WIDTH-1:0]               UART_TX_DATA,
   output logic                                UART_TX_VLD,
   output logic                                RF_WrEn,
   output logic                                RF_RdEn,
   output logic [RF_ADDR-1:0]                  RF_Address,
   output logic [DATA_WIDTH-1:0]               RF_WrData,
   input  logic [DATA_WIDTH-1:0]               RF_RdData,
   input  logic                                RF_RdData_VLD,
   output logic                                ALU_EN,
   output logic [3:0]                          ALU_FUN,
   input  logic [DATA_WIDTH*ALU_OUT_BYTES-1:0] ALU_OUT,
   input  logic                                ALU_OUT_VLD,
   output logic                                CLKG_EN,
   output logic                                CLKDIV_EN
);

   localparam int AW = DATA_WIDTH * ALU_OUT_BYTES;
   localparam int LW = $clog2(ALU_OUT_BYTES + 1);

   localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU     = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);
   localparam logic [DATA_WIDTH-1:0] CMD_BRD     = DATA_WIDTH'(8'hBC);
   localparam logic [DATA_WIDTH-1:0] CMD_BWR     = DATA_WIDTH'(8'hAC);

   typedef enum logic [4:0] {
      S_IDLE, S_WR_ADDR, S_RD_ADDR, S_BR_ADDR, S_BR_CNT, S_BW_ADDR, S_BW_CNT,
      S_BW_DATA, S_WR_DO, S_ALU_FUN, S_ALU_GO, S_ALU_WAIT, S_RD_DO, S_RD_WAIT,
      S_TX_IDLE, S_TX_PULSE, S_TX_HI, S_TX_LO
   } state_t;

   state_t                  state, state_nxt;
   logic [RF_ADDR-1:0]      addr;
   logic [DATA_WIDTH-1:0]   cnt;       // accesses still to do in the current frame
   logic [DATA_WIDTH-1:0]   wr_dat;
   logic [3:0]              fun;
   logic                    alu_mode;  // operand writes of a 0xCC frame lead into the ALU op
   logic [AW-1:0]           tx_buf;    // result bytes, LSB byte sent first
   logic [LW-1:0]           tx_left;
   logic [DATA_WIDTH-1:0]   tx_dat;
   logic [DATA_WIDTH-1:0]   tx_head;

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode; any result hand-off jumps straight to the pulse when TX is already idle
   always_comb begin
      state_t tx_entry;
      tx_entry  = UART_TX_Busy ? S_TX_IDLE : S_TX_PULSE;
      state_nxt = state;
      case (state)
         S_IDLE: if (UART_RX_VLD) begin
            case (UART_RX_DATA)
               CMD_WR:      state_nxt = S_WR_ADDR;
               CMD_RD:      state_nxt = S_RD_ADDR;
               CMD_ALU:     state_nxt = S_BW_DATA;
               CMD_ALU_NOP: state_nxt = S_ALU_FUN;
               CMD_BRD:     state_nxt = S_BR_ADDR;
               CMD_BWR:     state_nxt = S_BW_ADDR;
               default:     state_nxt = tx_entry;
            endcase
         end
         S_WR_ADDR:  if (UART_RX_VLD) state_nxt = S_BW_DATA;
         S_RD_ADDR:  if (UART_RX_VLD) state_nxt = S_RD_DO;
         S_BR_ADDR:  if (UART_RX_VLD) state_nxt = S_BR_CNT;
         S_BR_CNT:   if (UART_RX_VLD) state_nxt = (UART_RX_DATA == '0) ? S_IDLE : S_RD_DO;
         S_BW_ADDR:  if (UART_RX_VLD) state_nxt = S_BW_CNT;
         S_BW_CNT:   if (UART_RX_VLD) state_nxt = (UART_RX_DATA == '0) ? S_IDLE : S_BW_DATA;
         S_BW_DATA:  if (UART_RX_VLD) state_nxt = S_WR_DO;
         S_WR_DO: begin
            if (cnt == DATA_WIDTH'(1)) state_nxt = alu_mode ? S_ALU_FUN : S_IDLE;
            else                       state_nxt = S_BW_DATA;
         end
         S_ALU_FUN:  if (UART_RX_VLD) state_nxt = S_ALU_GO;
         S_ALU_GO:   state_nxt = ALU_OUT_VLD ? tx_entry : S_ALU_WAIT;
         S_ALU_WAIT: if (ALU_OUT_VLD) state_nxt = tx_entry;
         S_RD_DO:    state_nxt = S_RD_WAIT;
         S_RD_WAIT:  if (RF_RdData_VLD) state_nxt = tx_entry;
         S_TX_IDLE:  if (!UART_TX_Busy) state_nxt = S_TX_PULSE;
         S_TX_PULSE: state_nxt = S_TX_HI;
         S_TX_HI:    if (UART_TX_Busy) state_nxt = S_TX_LO;
         S_TX_LO: if (!UART_TX_Busy) begin
            if (tx_left != '0)   state_nxt = S_TX_PULSE;
            else if (cnt != '0)  state_nxt = S_RD_DO;
            else                 state_nxt = S_IDLE;
         end
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Strobes and enables are pure functions of the state
   always_comb begin
      RF_WrEn     = (state == S_WR_DO);
      RF_RdEn     = (state == S_RD_DO);
      ALU_EN      = (state == S_ALU_GO);
      CLKG_EN     = (state == S_ALU_GO) || (state == S_ALU_WAIT);
      UART_TX_VLD = (state == S_TX_PULSE);
   end

   // Byte to present on TX: a result captured this very cycle bypasses tx_buf
   always_comb begin
      tx_head = tx_buf[DATA_WIDTH-1:0];
      case (state)
         S_RD_WAIT:            tx_head = RF_RdData;
         S_ALU_GO, S_ALU_WAIT: tx_head = ALU_OUT[DATA_WIDTH-1:0];
         S_IDLE:               tx_head = ERR_CODE;
         default:              ;
      endcase
   end

   // Frame datapath: address/count/data capture, result latching and TX byte sequencing
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         addr      <= '0;
         cnt       <= '0;
         wr_dat    <= '0;
         fun       <= '0;
         alu_mode  <= 1'b0;
         tx_buf    <= '0;
         tx_left   <= '0;
         tx_dat    <= '0;
         CLKDIV_EN <= 1'b0;
      end else begin
         CLKDIV_EN <= 1'b1;
         case (state)
            S_IDLE: if (UART_RX_VLD) begin
               alu_mode <= (UART_RX_DATA == CMD_ALU);
               case (UART_RX_DATA)
                  CMD_ALU: begin
                     addr <= '0;
                     cnt  <= DATA_WIDTH'(2);
                  end
                  CMD_WR, CMD_RD, CMD_ALU_NOP, CMD_BRD, CMD_BWR: ;
                  default: begin
                     tx_buf  <= AW'(ERR_CODE);
                     tx_left <= LW'(1);
                     cnt     <= '0;
                  end
               endcase
            end
            S_WR_ADDR, S_RD_ADDR: if (UART_RX_VLD) begin
               addr <= UART_RX_DATA[RF_ADDR-1:0];
               cnt  <= DATA_WIDTH'(1);
            end
            S_BR_ADDR, S_BW_ADDR: if (UART_RX_VLD) addr <= UART_RX_DATA[RF_ADDR-1:0];
            S_BR_CNT, S_BW_CNT:   if (UART_RX_VLD) cnt <= UART_RX_DATA;
            S_BW_DATA:            if (UART_RX_VLD) wr_dat <= UART_RX_DATA;
            S_WR_DO: begin
               addr <= addr + RF_ADDR'(1);
               cnt  <= cnt - DATA_WIDTH'(1);
            end
            S_ALU_FUN: if (UART_RX_VLD) fun <= UART_RX_DATA[3:0];
            S_ALU_GO, S_ALU_WAIT: if (ALU_OUT_VLD) begin
               tx_buf  <= ALU_OUT;
               tx_left <= LW'(ALU_OUT_BYTES);
               cnt     <= '0;
            end
            S_RD_WAIT: if (RF_RdData_VLD) begin
               tx_buf  <= AW'(RF_RdData);
               tx_left <= LW'(1);
               addr    <= addr + RF_ADDR'(1);
               cnt     <= cnt - DATA_WIDTH'(1);
            end
            S_TX_PULSE: begin
               tx_buf  <= tx_buf >> DATA_WIDTH;
               tx_left <= tx_left - LW'(1);
            end
            default: ;
         endcase
         if (state_nxt == S_TX_PULSE && state != S_TX_PULSE) tx_dat <= tx_head;
      end
   end

   assign RF_Address   = addr;
   assign RF_WrData    = wr_dat;
   assign ALU_FUN      = fun;
   assign UART_TX_DATA = tx_dat;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Scoreboard bench for sys_ctrl_burst: directed frames push expected RF/ALU/TX events, a monitor pops and compares.
// Bench models an RF (2-cycle read), an ALU (3-cycle result) and a UART TX that goes busy for 4 cycles per byte.
// Latency and clock-gate timing are checked inline by the models and the stimulus process.
module tb_sys_ctrl_burst;

   localparam logic [1:0] EV_WR = 2'd0, EV_RD = 2'd1, EV_ALU = 2'd2, EV_TX = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] a;
      logic [7:0] b;
   } ev_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  UART_RX_DATA;
   logic        UART_RX_VLD;
   logic        UART_TX_Busy;
   logic [7:0]  UART_TX_DATA;
   logic        UART_TX_VLD;
   logic        RF_WrEn, RF_RdEn;
   logic [3:0]  RF_Address;
   logic [7:0]  RF_WrData;
   logic [7:0]  RF_RdData;
   logic        RF_RdData_VLD;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VLD;
   logic        CLKG_EN, CLKDIV_EN;

   int          checks = 0;
   int          errors = 0;
   ev_t         exp_q[$];
   logic [7:0]  mem [16];
   logic        force_busy = 1'b0;
   logic [15:0] alu_val = '0;

   sys_ctrl_burst dut (
      .CLK(CLK), .RST(RST),
      .UART_RX_DATA(UART_RX_DATA), .UART_RX_VLD(UART_RX_VLD),
      .UART_TX_Busy(UART_TX_Busy), .UART_TX_DATA(UART_TX_DATA), .UART_TX_VLD(UART_TX_VLD),
      .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
      .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .CLKG_EN(CLKG_EN), .CLKDIV_EN(CLKDIV_EN)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
      exp_q.push_back('{kind: k, a: a, b: b});
   endtask

   task automatic got_ev(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d a=%h b=%h with nothing expected", k, a, b);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== k || e.a !== a || e.b !== b) begin
            errors++;
            $display("FAIL event: got kind=%0d a=%h b=%h expected kind=%0d a=%h b=%h",
                     k, a, b, e.kind, e.a, e.b);
         end
      end
   endtask

   // Monitor: every strobe the DUT presents is matched against the head of the scoreboard
   always @(negedge CLK) begin
      if (RF_WrEn)     got_ev(EV_WR, 8'(RF_Address), RF_WrData);
      if (RF_RdEn)     got_ev(EV_RD, 8'(RF_Address), 8'h00);
      if (ALU_EN)      got_ev(EV_ALU, 8'(ALU_FUN), 8'h00);
      if (UART_TX_VLD) got_ev(EV_TX, 8'h00, UART_TX_DATA);
   end

   // RF model: writes land immediately, reads return two cycles after the strobe
   initial begin
      int   rd_cnt;
      logic [3:0] rd_addr;
      logic chk_tx_next;
      rd_cnt = 0; rd_addr = '0; chk_tx_next = 1'b0;
      RF_RdData = '0; RF_RdData_VLD = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[14] = 8'hB2;
      mem[15] = 8'hA1;
      forever begin
         @(negedge CLK);
         if (chk_tx_next) chk("tx_after_rd_lat", 32'(UART_TX_VLD), 32'd1);
         chk_tx_next   = 1'b0;
         RF_RdData_VLD = 1'b0;
         if (rd_cnt == 1) begin
            RF_RdData     = mem[rd_addr];
            RF_RdData_VLD = 1'b1;
            chk_tx_next   = !force_busy;
         end
         if (rd_cnt != 0) rd_cnt--;
         if (RF_WrEn) mem[RF_Address] = RF_WrData;
         if (RF_RdEn) begin rd_addr = RF_Address; rd_cnt = 2; end
      end
   end

   // ALU model: result three cycles after ALU_EN; clock gate must bracket the operation
   initial begin
      int alu_cd;
      alu_cd = 0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
      forever begin
         @(negedge CLK);
         if (ALU_OUT_VLD) begin
            ALU_OUT_VLD = 1'b0;
            chk("clkg_drop", 32'(CLKG_EN), 32'd0);
         end
         if (alu_cd != 0) begin
            alu_cd--;
            if (alu_cd == 0) begin
               chk("clkg_hold", 32'(CLKG_EN), 32'd1);
               ALU_OUT     = alu_val;
               ALU_OUT_VLD = 1'b1;
            end
         end
         if (ALU_EN) begin
            chk("clkg_with_en", 32'(CLKG_EN), 32'd1);
            alu_cd = 3;
         end
      end
   end

   // UART TX model: busy rises the cycle after a request and stays high for four cycles
   initial begin
      int   busy_cnt;
      logic tx_seen;
      busy_cnt = 0; tx_seen = 1'b0; UART_TX_Busy = 1'b0;
      forever begin
         @(negedge CLK);
         if (busy_cnt != 0) busy_cnt--;
         if (tx_seen) begin busy_cnt = 4; tx_seen = 1'b0; end
         if (UART_TX_VLD) begin
            chk("tx_vld_busy_low", 32'(UART_TX_Busy), 32'd0);
            tx_seen = 1'b1;
         end
         UART_TX_Busy = force_busy || (busy_cnt != 0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] b);
      UART_RX_DATA = b;
      UART_RX_VLD  = 1'b1;
      @(negedge CLK);
      UART_RX_VLD  = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b);
      send(b);
      idle(3);
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge CLK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d events outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      idle(10);
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {RF_WrEn, RF_RdEn, ALU_EN, UART_TX_VLD, CLKG_EN, CLKDIV_EN,
                 RF_Address, RF_WrData, ALU_FUN, UART_TX_DATA}, 32'd0);
   endtask

   initial begin
      RST = 1'b0; UART_RX_DATA = '0; UART_RX_VLD = 1'b0;
      idle(3);
      chk_all_zero("reset_outputs");
      RST = 1'b1;
      chk("clkdiv_at_release", 32'(CLKDIV_EN), 32'd0);
      @(negedge CLK);
      chk("clkdiv_after_clk", 32'(CLKDIV_EN), 32'd1);
      idle(2);

      // single write
      push(EV_WR, 8'h05, 8'h3C);
      send_gap(8'hAA); send_gap(8'h05); send(8'h3C);
      chk("wr_strobe_lat", 32'(RF_WrEn), 32'd1);
      drain("write", 50);

      // single read with TX held off by busy; a stray byte during the wait is dropped
      force_busy = 1'b1;
      push(EV_RD, 8'h05, 8'h00); push(EV_TX, 8'h00, 8'h3C);
      send_gap(8'hBB); send(8'h05);
      chk("rd_strobe_lat", 32'(RF_RdEn), 32'd1);
      idle(8);
      send(8'h55);
      idle(4);
      chk("tx_held_while_busy", 32'(UART_TX_VLD), 32'd0);
      force_busy = 1'b0;
      drain("read", 100);

      // ALU with operands, 16-bit result sent LSB first
      alu_val = 16'h000A;
      push(EV_WR, 8'h00, 8'h07); push(EV_WR, 8'h01, 8'h03); push(EV_ALU, 8'h00, 8'h00);
      push(EV_TX, 8'h00, 8'h0A); push(EV_TX, 8'h00, 8'h00);
      send_gap(8'hCC); send_gap(8'h07); send_gap(8'h03); send(8'h00);
      drain("alu_ops", 200);

      // burst read wrapping past the top address
      push(EV_RD, 8'h0E, 8'h00); push(EV_TX, 8'h00, 8'hB2);
      push(EV_RD, 8'h0F, 8'h00); push(EV_TX, 8'h00, 8'hA1);
      push(EV_RD, 8'h00, 8'h00); push(EV_TX, 8'h00, 8'h07);
      send_gap(8'hBC); send_gap(8'h0E); send(8'h03);
      drain("burst_read", 300);

      // zero-length burst read: nothing may appear
      send_gap(8'hBC); send_gap(8'h02); send(8'h00);
      idle(20);

      // burst write wrapping, then read both locations back
      push(EV_WR, 8'h0F, 8'h11); push(EV_WR, 8'h00, 8'h22);
      send_gap(8'hAC); send_gap(8'h0F); send_gap(8'h02); send_gap(8'h11); send(8'h22);
      chk("bw_strobe_lat", 32'(RF_WrEn), 32'd1);
      drain("burst_write", 50);
      push(EV_RD, 8'h0F, 8'h00); push(EV_TX, 8'h00, 8'h11);
      send_gap(8'hBB); send(8'h0F);
      drain("readback_f", 100);
      push(EV_RD, 8'h00, 8'h00); push(EV_TX, 8'h00, 8'h22);
      send_gap(8'hBB); send(8'h00);
      drain("readback_0", 100);

      // unknown command
      push(EV_TX, 8'h00, 8'hEE);
      send(8'h55);
      drain("unknown", 100);

      // ALU without operands
      alu_val = 16'h5AA5;
      push(EV_ALU, 8'h03, 8'h00); push(EV_TX, 8'h00, 8'hA5); push(EV_TX, 8'h00, 8'h5A);
      send_gap(8'hDD); send(8'h03);
      drain("alu_nop", 200);

      // reset mid-frame, then a clean read frame
      send_gap(8'hAA);
      RST = 1'b0;
      @(negedge CLK);
      chk_all_zero("midframe_reset");
      idle(2);
      RST = 1'b1;
      idle(3);
      push(EV_RD, 8'h01, 8'h00); push(EV_TX, 8'h00, 8'h03);
      send_gap(8'hBB); send(8'h01);
      drain("post_reset_read", 100);

      idle(20);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sys_ctrl_burst.md
Name: sys_ctrl_burst

Overview:
Parametrised next-generation system controller in the REF_CLK domain. It decodes byte-wide command frames from the synchronised UART RX stream and drives the register file and ALU. Results go back to the UART TX path as bytes under a busy handshake. Beyond the single-access controller it adds burst read/write, configurable ALU result width, and an unknown-command error response.

Parameters:
DATA_WIDTH, 8, UART/RF byte width
RF_ADDR, 4, register file address width; address bytes truncated to low RF_ADDR bits
ALU_OUT_BYTES, 2, ALU result width in bytes (ALU_OUT is DATA_WIDTH*ALU_OUT_BYTES)
ERR_CODE, 8'hEE, byte transmitted on unknown command

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  asynchronous active-low reset
UART_RX_DATA  in  DATA_WIDTH  synchronised RX byte
UART_RX_VLD  in  1  one-cycle pulse: RX byte valid
UART_TX_Busy  in  1  synchronised TX busy
UART_TX_DATA  out  DATA_WIDTH  TX byte
UART_TX_VLD  out  1  one-cycle TX request
RF_WrEn  out  1  RF write strobe
RF_RdEn  out  1  RF read strobe
RF_Address  out  RF_ADDR  RF address
RF_WrData  out  DATA_WIDTH  RF write data
RF_RdData  in  DATA_WIDTH  RF read data
RF_RdData_VLD  in  1  RF read data valid
ALU_EN  out  1  ALU enable
ALU_FUN  out  4  ALU function
ALU_OUT  in  DATA_WIDTH*ALU_OUT_BYTES  ALU result
ALU_OUT_VLD  in  1  ALU result valid
CLKG_EN  out  1  ALU clock-gate enable
CLKDIV_EN  out  1  TX clock divider enable

Behaviour:
- Reset: all outputs 0, except CLKDIV_EN, which goes to 1 on the first clock after reset release and then stays 1. FSM returns to IDLE.
- Strobes: RF_WrEn, RF_RdEn, ALU_EN and UART_TX_VLD are one-cycle pulses.
- Bytes are consumed only on UART_RX_VLD. Non-VLD cycles hold the state.
- Commands (first byte, IDLE):
  - 0xAA write: addr, data. Issues RF_WrEn in the cycle after the data byte arrives.
  - 0xBB read: addr. Issues RF_RdEn, waits for RF_RdData_VLD, transmits RdData.
  - 0xCC ALU with operands: A, B, fun. Writes A to addr 0, then B to addr 1 (one write per RX byte). Then ALU op.
  - 0xDD ALU, no operands: fun. Then ALU op.
  - 0xBC burst read: addr, count N.
    - Reads addr..addr+N-1, each read then TX before the next read.
    - Address wraps modulo 2^RF_ADDR.
    - N=0 means no access and no TX, return to IDLE.
  - 0xAC burst write: addr, count N, then N data bytes.
    - Each data byte is written with address post-increment and the same wrap.
    - N=0 returns to IDLE immediately.
  - Any other first byte: transmit ERR_CODE once, return to IDLE.
- ALU op:
  - CLKG_EN is driven high in the cycle ALU_EN pulses (ALU_FUN = low 4 bits of fun byte) and held until ALU_OUT_VLD.
  - CLKG_EN drops the cycle after ALU_OUT_VLD.
  - ALU_OUT is latched and sent as ALU_OUT_BYTES bytes, LSB byte first.
- TX handshake, per byte:
  - Wait until UART_TX_Busy=0.
  - Pulse UART_TX_VLD with UART_TX_DATA stable.
  - Wait for Busy=1, then Busy=0, before the next byte.
  - UART_TX_DATA holds its value until the next VLD.
- RX bytes arriving while transmitting or waiting on RF/ALU are dropped. The frame does not advance.
- RX pulse in the same cycle as RF_RdData_VLD/ALU_OUT_VLD: the result is taken, the RX byte is dropped.
- Reset mid-frame: outputs and FSM clear immediately (async). The partial frame is discarded.
- Latencies:
  - Write strobe: 1 cycle after last byte's VLD.
  - Read strobe: 1 cycle after addr VLD.
  - First TX VLD: 1 cycle after RdData_VLD if Busy=0.

Test Plan:
- Reset release: all outputs 0; CLKDIV_EN=1 one cycle later. Then AA,05,3C -> RF_WrEn pulse, Address=5, WrData=3C.
- BB,05 with RF returning 3C -> RF_RdEn pulse, Address=5; one TX VLD with 3C after Busy=0.
- CC,07,03,00 with ALU_OUT=000A -> writes 07@0 and 03@1; ALU_EN with FUN=0; CLKG_EN high until VLD; TX 0A then 00, each gated by Busy high/low.
- BC,0E,03 -> reads at 0E, 0F, 00 (wrap), three TX bytes in order. BC,02,00 -> no strobes.
- AC,0F,02,11,22 -> writes 11@F, 22@0. Unknown 0x55 -> single TX of EE.
- Reset asserted between AA and its addr byte -> all outputs 0; a following BB,01 frame decodes correctly.
